// File: rtl/nios_debug_scan_master.sv
// Virtual-JTAG scan sequencer: UIR -> CDR -> SDR -> UDR -> RTI on a divided vji_tck.
// Optional macro NIOS_DEBUG_SCAN_IR_SKIP_EN skips UIR when the IR matches the cached IR.
module nios_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int PERIOD = 2 * TCK_DIV;
  localparam int DIV_W  = $clog2(PERIOD);
  localparam int CNT_W  = $clog2(DR_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_DIV);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DR_WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic                r_tdo_q;
  logic                w_accept, w_scan, w_boundary, w_rise, w_skip_uir;
  logic                w_tck_nxt, w_tdi_nxt, w_ready_nxt, w_rsp_nxt;
  logic [4:0]          w_strobe_nxt;

  assign w_accept   = cmd_valid & cmd_ready;
  assign w_scan     = r_state inside {S_UIR, S_CDR, S_SDR, S_UDR, S_RTI};
  // A period ends on the edge that drives vji_tck low; the rise sits TCK_DIV cycles in.
  assign w_boundary = w_scan && (r_div == DIV_LAST);
  assign w_rise     = (r_state == S_SDR) && (r_div == DIV_RISE);

`ifdef NIOS_DEBUG_SCAN_IR_SKIP_EN
  logic                r_ir_cached;
  logic [IR_WIDTH-1:0] r_last_ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_cached <= 1'b0;
      r_last_ir   <= '0;
    end else if (r_state == S_UIR && w_boundary) begin
      r_ir_cached <= 1'b1;
      r_last_ir   <= vji_ir_in;
    end
  end

  assign w_skip_uir = r_ir_cached && (cmd_ir == r_last_ir);
`else
  assign w_skip_uir = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = (w_scan && !w_boundary) ? r_div + DIV_W'(1) : '0;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_accept ? (w_skip_uir ? S_CDR : S_UIR) : S_IDLE;
      S_UIR:   if (w_boundary) w_state_nxt = S_CDR;
      S_CDR:   if (w_boundary) w_state_nxt = S_SDR;
      S_SDR:   if (w_boundary && r_cnt == CNT_LAST) w_state_nxt = S_UDR;
      S_UDR:   if (w_boundary) w_state_nxt = S_RTI;
      S_RTI:   if (w_boundary) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_shreg_nxt = r_shreg;
    if (w_accept)                            w_shreg_nxt = cmd_dr;
    else if (r_state == S_SDR && w_boundary) w_shreg_nxt = {r_tdo_q, r_shreg[DR_WIDTH-1:1]};
  end

  // NOTE: outputs are decoded from the *next* state and then registered, so every
  // output is a flop and nothing passes combinationally from inputs to outputs.
  always_comb begin
    w_strobe_nxt = '0;
    w_tdi_nxt    = 1'b0;
    w_ready_nxt  = 1'b0;
    w_rsp_nxt    = 1'b0;
    case (w_state_nxt)
      S_IDLE:  w_ready_nxt = 1'b1;
      S_UIR:   w_strobe_nxt = 5'b00001;
      S_CDR:   w_strobe_nxt = 5'b00010;
      S_SDR: begin
        w_strobe_nxt = 5'b00100;
        w_tdi_nxt    = w_shreg_nxt[0];
      end
      S_UDR:   w_strobe_nxt = 5'b01000;
      S_RTI:   w_strobe_nxt = 5'b10000;
      S_DONE: begin
        w_ready_nxt = 1'b1;
        w_rsp_nxt   = 1'b1;
      end
      default: w_ready_nxt = 1'b0;
    endcase
    w_tck_nxt = (w_strobe_nxt != 5'b00000) && (w_div_nxt >= DIV_HIGH);
  end

  // NOTE: the shift register is reset too, so a mid-scan reset leaves no stale scan data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_tdo_q   <= 1'b0;
      vji_ir_in <= '0;
    end else begin
      r_shreg <= w_shreg_nxt;
      if (w_rise) r_tdo_q <= vji_tdo;
      if (w_accept) begin
        r_cnt     <= '0;
        vji_ir_in <= cmd_ir;
      end else if (r_state == S_SDR && w_boundary) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
      vji_tck   <= 1'b0;
      vji_tdi   <= 1'b0;
      {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir} <= '0;
    end else begin
      cmd_ready <= w_ready_nxt;
      rsp_valid <= w_rsp_nxt;
      if (w_rsp_nxt) rsp_dr <= r_shreg;
      vji_tck   <= w_tck_nxt;
      vji_tdi   <= w_tdi_nxt;
      {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir} <= w_strobe_nxt;
    end
  end

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Directed bench for nios_debug_scan_master (default parameters).
// Scan latency is counted in falling clk edges after the accept edge, up to the one where rsp_valid is seen.
module tb_nios_debug_scan_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_ir = '0;
  logic [37:0] cmd_dr = '0;
  logic        rsp_valid;
  logic [37:0] rsp_dr;
  logic        vji_tck, vji_tdi, vji_tdo;
  logic [1:0]  vji_ir_in;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [1:0]  tdo_mode = 2'd0;  // 0: loopback, 1: constant 1, 2: constant 0
  logic [4:0]  strobes;

  int checks = 0;
  int failures = 0;

  assign vji_tdo = (tdo_mode == 2'd0) ? vji_tdi : (tdo_mode == 2'd1);
  assign strobes = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};

  nios_debug_scan_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_dr(rsp_dr),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

  // Monitor: cumulative per-cycle counts sampled on the falling edge.
  int cyc = 0, c_uir = 0, c_cdr = 0, c_sdr = 0, c_udr = 0, c_rti = 0;
  int sdr_rises = 0, idle_rises = 0;
  int t_uir = 0, t_cdr = 0, t_sdr = 0, t_udr = 0, t_rti = 0;
  logic p_tck = 1'b0;
  logic [4:0] p_str = '0;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    c_uir <= c_uir + int'(vji_uir);
    c_cdr <= c_cdr + int'(vji_cdr);
    c_sdr <= c_sdr + int'(vji_sdr);
    c_udr <= c_udr + int'(vji_udr);
    c_rti <= c_rti + int'(vji_rti);
    if (vji_tck && !p_tck) begin
      if (vji_sdr) sdr_rises <= sdr_rises + 1;
      if (strobes == 5'b0) idle_rises <= idle_rises + 1;
    end
    if (vji_uir && !p_str[0]) t_uir <= cyc;
    if (vji_cdr && !p_str[1]) t_cdr <= cyc;
    if (vji_sdr && !p_str[2]) t_sdr <= cyc;
    if (vji_udr && !p_str[3]) t_udr <= cyc;
    if (vji_rti && !p_str[4]) t_rti <= cyc;
    p_tck <= vji_tck;
    p_str <= strobes;
  end

  int s_cyc, s_uir, s_cdr, s_sdr, s_udr, s_rti, s_rises;
  int d_uir, d_cdr, d_sdr, d_udr, d_rti, d_rises;

  // Stimulus only: one command, then wait (bounded) for its response. lat = -1 on timeout.
  task automatic do_scan(input logic [1:0] ir, input logic [37:0] dr, output int lat);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    s_cyc = cyc; s_uir = c_uir; s_cdr = c_cdr; s_sdr = c_sdr; s_udr = c_udr; s_rti = c_rti;
    s_rises = sdr_rises;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_ir = ~ir; cmd_dr = ~dr;
    n = 1;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    lat = rsp_valid ? n : -1;
    d_uir = c_uir - s_uir; d_cdr = c_cdr - s_cdr; d_sdr = c_sdr - s_sdr;
    d_udr = c_udr - s_udr; d_rti = c_rti - s_rti; d_rises = sdr_rises - s_rises;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, vji_tck, vji_tdi, strobes, rsp_valid} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0", {cmd_ready, vji_tck, vji_tdi, strobes, rsp_valid});
    end
    checks++;
    if (rsp_dr !== 38'h0) begin
      failures++; $display("FAIL reset_rsp_dr: got %h expected 0", rsp_dr);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_loopback;
    int lat;
    tdo_mode = 2'd0;
    do_scan(2'b01, 38'h2A_5555_AAAA, lat);
    checks++;
    if (rsp_dr !== 38'h2A_5555_AAAA) begin
      failures++; $display("FAIL loopback_rsp: got %h expected 2a5555aaaa", rsp_dr);
    end
    checks++;
    if (vji_ir_in !== 2'b01) begin
      failures++; $display("FAIL loopback_ir: got %b expected 01", vji_ir_in);
    end
    checks++;
    if (lat !== 169) begin
      failures++; $display("FAIL loopback_latency: got %0d expected 169", lat);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, vji_tck, vji_tdi} !== 4'b0100) begin
      failures++; $display("FAIL rsp_pulse_idle: got %b expected 0100", {rsp_valid, cmd_ready, vji_tck, vji_tdi});
    end
    checks++;
    if (rsp_dr !== 38'h2A_5555_AAAA) begin
      failures++; $display("FAIL rsp_hold: got %h expected 2a5555aaaa", rsp_dr);
    end
    do_scan(2'b11, 38'h15_0F0F_3C3C, lat);
    checks++;
    if (rsp_dr !== 38'h15_0F0F_3C3C || vji_ir_in !== 2'b11) begin
      failures++; $display("FAIL loopback2: got %h/%b expected 150f0f3c3c/11", rsp_dr, vji_ir_in);
    end
  endtask

  task automatic test_const_tdo;
    int lat;
    tdo_mode = 2'd1;
    do_scan(2'b10, 38'h0, lat);
    checks++;
    if (rsp_dr !== 38'h3F_FFFF_FFFF) begin
      failures++; $display("FAIL const1_rsp: got %h expected 3fffffffff", rsp_dr);
    end
    checks++;
    if (d_rises !== 38) begin
      failures++; $display("FAIL sdr_tck_rises: got %0d expected 38", d_rises);
    end
    checks++;
    if ({d_uir, d_cdr, d_udr, d_rti} !== {32'd4, 32'd4, 32'd4, 32'd4} || d_sdr !== 152) begin
      failures++;
      $display("FAIL strobe_widths: got uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d expected 4 4 152 4 4",
               d_uir, d_cdr, d_sdr, d_udr, d_rti);
    end
    checks++;
    if (!(t_uir > s_cyc && t_uir < t_cdr && t_cdr < t_sdr && t_sdr < t_udr && t_udr < t_rti)) begin
      failures++;
      $display("FAIL strobe_order: got uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d expected increasing after %0d",
               t_uir, t_cdr, t_sdr, t_udr, t_rti, s_cyc);
    end
    checks++;
    if (lat !== 169) begin
      failures++; $display("FAIL const1_latency: got %0d expected 169", lat);
    end
    tdo_mode = 2'd2;
    do_scan(2'b10, 38'h3F_FFFF_FFFF, lat);
    checks++;
    if (rsp_dr !== 38'h0) begin
      failures++; $display("FAIL const0_rsp: got %h expected 0", rsp_dr);
    end
    tdo_mode = 2'd0;
  endtask

  task automatic test_back_to_back;
    int n, base_idle;
    tdo_mode = 2'd0;
    base_idle = idle_rises;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_dr = 38'h01_2345_6789;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_ir = 2'b11; cmd_dr = 38'h3A_BCDE_F012;
    n = 1;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 169 || rsp_dr !== 38'h01_2345_6789) begin
      failures++; $display("FAIL b2b_first: got lat=%0d rsp=%h expected 169/0123456789", n, rsp_dr);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_ready_in_done: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({vji_uir, cmd_ready, rsp_valid, vji_ir_in} !== 5'b10011) begin
      failures++; $display("FAIL b2b_second_start: got %b expected 10011", {vji_uir, cmd_ready, rsp_valid, vji_ir_in});
    end
    n = 1;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 169 || rsp_dr !== 38'h3A_BCDE_F012) begin
      failures++; $display("FAIL b2b_second: got lat=%0d rsp=%h expected 169/3abcdef012", n, rsp_dr);
    end
    checks++;
    if (idle_rises - base_idle !== 0) begin
      failures++; $display("FAIL b2b_idle_tck: got %0d expected 0", idle_rises - base_idle);
    end
  endtask

  task automatic test_reset_mid_sdr;
    int n, base, lat;
    tdo_mode = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_dr = 38'h2F_0000_FFFF;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    base = sdr_rises;
    n = 0;
    while (sdr_rises - base < 10 && n < 500) begin @(posedge clk); n++; end
    @(negedge clk);
    checks++;
    if (vji_sdr !== 1'b1) begin
      failures++; $display("FAIL mid_sdr_reached: got %b expected 1", vji_sdr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, vji_tck, vji_tdi, vji_ir_in, strobes, rsp_valid} !== 11'b0 || rsp_dr !== 38'h0) begin
      failures++;
      $display("FAIL mid_sdr_reset: got %b rsp=%h expected all 0",
               {cmd_ready, vji_tck, vji_tdi, vji_ir_in, strobes, rsp_valid}, rsp_dr);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_scan(2'b01, 38'h11_2233_4455, lat);
    checks++;
    if (rsp_dr !== 38'h11_2233_4455 || lat !== 169 || d_uir !== 4) begin
      failures++; $display("FAIL after_reset_scan: got rsp=%h lat=%0d uir=%0d expected 1122334455/169/4", rsp_dr, lat, d_uir);
    end
  endtask

  task automatic test_ir_skip;
    int lat;
    tdo_mode = 2'd0;
    do_scan(2'b10, 38'h0A_AAAA_0001, lat);
    checks++;
    if (lat !== 169 || d_uir !== 4 || rsp_dr !== 38'h0A_AAAA_0001) begin
      failures++; $display("FAIL skip_first: got lat=%0d uir=%0d rsp=%h expected 169/4/0aaaaa0001", lat, d_uir, rsp_dr);
    end
    do_scan(2'b10, 38'h35_5555_8000, lat);
`ifdef NIOS_DEBUG_SCAN_IR_SKIP_EN
    checks++;
    if (lat !== 165 || d_uir !== 0 || rsp_dr !== 38'h35_5555_8000) begin
      failures++; $display("FAIL skip_same_ir: got lat=%0d uir=%0d rsp=%h expected 165/0/3555558000", lat, d_uir, rsp_dr);
    end
`else
    checks++;
    if (lat !== 169 || d_uir !== 4 || rsp_dr !== 38'h35_5555_8000) begin
      failures++; $display("FAIL same_ir_no_skip: got lat=%0d uir=%0d rsp=%h expected 169/4/3555558000", lat, d_uir, rsp_dr);
    end
`endif
    do_scan(2'b11, 38'h00_0000_0001, lat);
    checks++;
    if (lat !== 169 || d_uir !== 4 || vji_ir_in !== 2'b11) begin
      failures++; $display("FAIL skip_new_ir: got lat=%0d uir=%0d ir=%b expected 169/4/11", lat, d_uir, vji_ir_in);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_const_tdo();
    test_back_to_back();
    test_reset_mid_sdr();
    test_ir_skip();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_debug_scan_master.md
# nios_debug_scan_master

Single-clock scan sequencer that drives the Nios II debug slave's virtual-JTAG side: `vji_tck`, `vji_tdi`, `vji_ir_in` and the virtual state strobes. It captures `vji_tdo` and returns the shifted-out data register. It accepts one command at a time, each an IR value plus a DR word, over a valid/ready interface in the system clock domain. It generates the full UIR → CDR → SDR → UDR → RTI sequence on a divided `vji_tck`. It sits in simulation benches and embedded-debug builds where no physical JTAG hub is present.

## Interface
Parameters:
- `DR_WIDTH`, 38: scan data register length in bits.
- `IR_WIDTH`, 2: virtual IR width.
- `TCK_DIV`, 2: `vji_tck` half-period in `clk` cycles. Minimum 1.

Ports:
- `clk`  in  1  system clock. All state is clocked on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block idle; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_ir`  in  `IR_WIDTH`  IR value for this scan.
- `cmd_dr`  in  `DR_WIDTH`  data to shift in, LSB first.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_dr` is valid.
- `rsp_dr`  out  `DR_WIDTH`  captured TDO data. Held until the next completion.
- `vji_tck`  out  1  scan clock.
- `vji_tdi`  out  1  serial data to the slave.
- `vji_tdo`  in  1  serial data from the slave.
- `vji_ir_in`  out  `IR_WIDTH`  current virtual IR.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each  virtual JTAG state indicators.

## Operation
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI, DONE.
- IDLE: `cmd_ready`=1, `vji_tck`=0, all strobes 0.
- On accept:
  - latch `cmd_ir` into `vji_ir_in` and `cmd_dr` into the shift register `shreg`;
  - clear the bit counter;
  - go to UIR.
- After accept, changes on `cmd_ir`/`cmd_dr` are ignored until the next accept.
- Each of UIR, CDR, UDR and RTI lasts exactly one tck period. The matching strobe is high for the whole period.
- SDR lasts exactly `DR_WIDTH` tck periods. `vji_sdr` stays high throughout.
- In SDR:
  - `vji_tdi` = `shreg[0]`;
  - on the clk edge that drives `vji_tck` high, sample `vji_tdo` into `tdo_q`;
  - on the clk edge that drives `vji_tck` low, shift: `shreg <= {tdo_q, shreg[DR_WIDTH-1:1]}` and increment the bit counter.
- Bit counter width is `$clog2(DR_WIDTH+1)`. SDR exits when the counter reaches `DR_WIDTH`.
- `vji_tdi` is 0 outside SDR.
- After RTI, the FSM enters DONE for one clk cycle:
  - `rsp_dr <= shreg`;
  - `rsp_valid` = 1;
  - `cmd_ready` = 1 in the same cycle, so back-to-back accept is allowed;
  - next state is IDLE, or UIR/CDR if a command is accepted in this cycle.
- Async reset, including mid-scan:
  - immediate return to IDLE;
  - `vji_tck`, all strobes, `vji_tdi`, `vji_ir_in` and `rsp_valid` = 0;
  - `rsp_dr` = 0;
  - IR-cache valid cleared.

## Timing
- tck period = `2*TCK_DIV` clk cycles.
- Period boundaries are tck falling edges. State, strobes and `vji_tdi` change only at boundaries.
- `vji_tck` rises `TCK_DIV` clk cycles into each period.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from the accept edge to the `rsp_valid` cycle is `(DR_WIDTH+4)*2*TCK_DIV + 1` clk cycles. Defaults give 169.
- If `IR_SKIP` applies (see Configuration), latency drops by `2*TCK_DIV`.
- Exactly `DR_WIDTH` rising `vji_tck` edges occur while `vji_sdr`=1. No tck edges occur in IDLE.

## Configuration
- `NIOS_DEBUG_SCAN_IR_SKIP_EN`:
  - **Defined:** the block keeps `last_ir` and an `ir_cached` flag. When the accepted `cmd_ir` equals `last_ir` and `ir_cached`=1, UIR is skipped and the scan starts at CDR. `ir_cached` is set after any UIR.
  - **Undefined:** every scan includes UIR. No `last_ir` register exists.

## Test plan
- Reset: assert `reset_n`=0 → `cmd_ready`=0 during reset then 1, and `vji_tck`/strobes/`rsp_valid`/`rsp_dr` = 0.
- Loopback: tie `vji_tdo` to `vji_tdi`, send `cmd_ir`=2'b01, `cmd_dr`=38'h2A_5555_AAAA → `rsp_dr`=38'h2A_5555_AAAA, `vji_ir_in`=2'b01, `rsp_valid` at 169 cycles.
- Constant TDO: `vji_tdo`=1, `cmd_dr`=0 → `rsp_dr`=38'h3F_FFFF_FFFF. Exactly 38 tck rises with `vji_sdr`=1; UIR/CDR/UDR/RTI each high 4 clk cycles, in that order.
- Back-to-back: hold `cmd_valid` for two commands → second accepted in the `rsp_valid` cycle, with no idle tck edges between scans.
- Reset mid-SDR after 10 bits → all outputs idle in the same cycle. A following command runs the full sequence including UIR, and `rsp_dr` reflects only the new scan.
- With `NIOS_DEBUG_SCAN_IR_SKIP_EN` defined:
  - two commands with `cmd_ir`=2'b10 → the second has no `vji_uir` pulse and latency 165;
  - a third command with `cmd_ir`=2'b11 → UIR present, latency 169.
